// File: rtl/trigger_frame_pkg.sv
// trigger_frame_pkg: shared latency/magic constants, FSM encoding and beat field offsets
package trigger_frame_pkg;
    localparam int TRIGGER_LATENCY = 2;
    localparam logic [7:0] HEADER_MAGIC = 8'hAA;
    localparam logic [7:0] FOOTER_MAGIC = 8'h55;
    localparam int MAGIC_LSB = 120;
    localparam int CHANNEL_LSB = 112;
    localparam int TIMESTAMP_LSB = 64;
    localparam int COUNT_LSB = 96;
    localparam int GAIN_BIT = 95;
    localparam int OVERFLOW_BIT = 94;
    typedef enum logic [1:0] {IDLE, SKIP, DATA, CLOSE} state_t;
endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: synchronous FIFO with flush, full flag and free-slot count
module frame_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign free = (AW+1)'(DEPTH) - count;
    assign pop = rd_en && !empty;
    // a full FIFO still accepts a write when the same cycle pops
    assign push = wr_en && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/trigger_frame_builder.sv
// trigger_frame_builder: gain-selects delayed samples and frames them as header/data/footer
// AXI4-Stream packets through an output FIFO; the input side never stalls.
module trigger_frame_builder
    import trigger_frame_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SAMPLE_NUM_PER_CLK = 8,
    parameter int MAX_PRE_ACQUISITION_LENGTH = 2,
    parameter int TIMESTAMP_WIDTH = 48,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                          ACLK,
    input  logic                                          ARESET,
    input  logic                                          SET_CONFIG,
    input  logic [7:0]                                    CHANNEL_ID,
    input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH)-1:0] PRE_ACQUISITION_LENGTH,
    input  logic [SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK-1:0]    H_GAIN_TDATA,
    input  logic [SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK-1:0]    L_GAIN_TDATA,
    input  logic                                          TRIGGER,
    input  logic                                          SATURATION_FLAG,
    output logic [SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK-1:0]    M_AXIS_TDATA,
    output logic                                          M_AXIS_TVALID,
    input  logic                                          M_AXIS_TREADY,
    output logic                                          M_AXIS_TLAST,
    output logic [15:0]                                   DROPPED_FRAME_COUNT
);
    localparam int DW = SAMPLE_WIDTH * SAMPLE_NUM_PER_CLK;
    localparam int DL = TRIGGER_LATENCY + MAX_PRE_ACQUISITION_LENGTH;
    localparam int TW = $clog2(DL);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    logic [DW-1:0] h_dly [DL];
    logic [DW-1:0] l_dly [DL];
    logic [DW-1:0] hold, header, footer;
    logic hold_sel;
    logic [TW-1:0] tap;
    logic [TIMESTAMP_WIDTH-1:0] timestamp;
    state_t state, state_n;
    logic [15:0] beat_count, beat_n, drop_n;
    logic gain_used, gain_n, overflow, ovf_n, data_ok;
    logic wr_en, full, empty;
    logic [DW:0] wr_data, rd_data;
    logic [FW-1:0] free;
    // tap k-1 of the shift line is the sample from k cycles ago
    assign tap = TW'(TRIGGER_LATENCY - 1) + TW'(PRE_ACQUISITION_LENGTH);
    always_ff @(posedge ACLK) begin
        h_dly[0] <= H_GAIN_TDATA;
        l_dly[0] <= L_GAIN_TDATA;
        for (int i = 1; i < DL; i++) begin
            h_dly[i] <= h_dly[i-1];
            l_dly[i] <= l_dly[i-1];
        end
        hold <= SATURATION_FLAG ? l_dly[tap] : h_dly[tap];
        hold_sel <= SATURATION_FLAG;
    end
    always_comb begin
        header = '0;
        header[MAGIC_LSB +: 8] = HEADER_MAGIC;
        header[CHANNEL_LSB +: 8] = CHANNEL_ID;
        header[TIMESTAMP_LSB +: TIMESTAMP_WIDTH] = timestamp;
        footer = '0;
        footer[MAGIC_LSB +: 8] = FOOTER_MAGIC;
        footer[CHANNEL_LSB +: 8] = CHANNEL_ID;
        footer[COUNT_LSB +: 16] = beat_count;
        footer[GAIN_BIT] = gain_used;
        footer[OVERFLOW_BIT] = overflow;
    end
    // data beats keep one slot in reserve so the footer always fits
    assign data_ok = free >= FW'(2);
    always_comb begin
        state_n = state;
        wr_en = 1'b0;
        wr_data = '0;
        beat_n = beat_count;
        gain_n = gain_used;
        ovf_n = overflow;
        drop_n = DROPPED_FRAME_COUNT;
        case (state)
            IDLE: if (TRIGGER) begin
                beat_n = '0;
                gain_n = 1'b0;
                ovf_n = 1'b0;
                if (full) begin
                    drop_n = DROPPED_FRAME_COUNT + 16'(DROPPED_FRAME_COUNT != '1);
                    state_n = SKIP;
                end else begin
                    wr_en = 1'b1;
                    wr_data = {1'b0, header};
                    state_n = DATA;
                end
            end
            SKIP: state_n = TRIGGER ? SKIP : IDLE;
            DATA, CLOSE: if (state == CLOSE && !TRIGGER) begin
                wr_en = 1'b1;
                wr_data = {1'b1, footer};
                state_n = IDLE;
            end else begin
                wr_en = data_ok;
                wr_data = {1'b0, hold};
                ovf_n = overflow | !data_ok;
                if (data_ok) begin
                    beat_n = beat_count + 16'(beat_count != '1);
                    gain_n = gain_used | hold_sel;
                end
                state_n = TRIGGER ? DATA : CLOSE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
            timestamp <= '0;
            beat_count <= '0;
            gain_used <= 1'b0;
            overflow <= 1'b0;
            DROPPED_FRAME_COUNT <= '0;
        end else if (SET_CONFIG) begin
            state <= IDLE;
            timestamp <= '0;
            beat_count <= '0;
            gain_used <= 1'b0;
            overflow <= 1'b0;
            DROPPED_FRAME_COUNT <= '0;
        end else begin
            state <= state_n;
            timestamp <= timestamp + 1'b1;
            beat_count <= beat_n;
            gain_used <= gain_n;
            overflow <= ovf_n;
            DROPPED_FRAME_COUNT <= drop_n;
        end
    end
    frame_fifo #(.WIDTH(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(ACLK),
        .rst(ARESET),
        .flush(SET_CONFIG),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(M_AXIS_TREADY),
        .rd_data(rd_data),
        .full(full),
        .empty(empty),
        .free(free)
    );
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = rd_data;
    assign M_AXIS_TVALID = !empty;
endmodule

// File: tb/tb_trigger_frame_builder.sv
// tb_trigger_frame_builder: directed windows with a scoreboard queue drained by a monitor
// that compares every accepted output beat against the expected frame stream.
module tb_trigger_frame_builder;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic SET_CONFIG = 1'b0;
    logic [7:0] CHANNEL_ID = 8'h3C;
    logic [0:0] pre_len = 1'b1;
    logic [127:0] H_GAIN_TDATA, L_GAIN_TDATA, M_AXIS_TDATA;
    logic TRIGGER = 1'b0;
    logic SATURATION_FLAG = 1'b0;
    logic M_AXIS_TVALID, M_AXIS_TLAST;
    logic M_AXIS_TREADY = 1'b1;
    logic [15:0] DROPPED_FRAME_COUNT;
    logic [47:0] ts_m;
    logic [47:0] r;
    logic [128:0] sb [$];
    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    // sample tags: every beat carries the cycle number it was presented in
    always @(posedge ACLK or posedge ARESET)
        if (ARESET) ts_m <= '0;
        else if (SET_CONFIG) ts_m <= '0;
        else ts_m <= ts_m + 1'b1;
    assign H_GAIN_TDATA = {8'hA1, 104'h0, ts_m[15:0]};
    assign L_GAIN_TDATA = {8'hB2, 104'h0, ts_m[15:0]};

    trigger_frame_builder dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .SET_CONFIG(SET_CONFIG),
        .CHANNEL_ID(CHANNEL_ID),
        .PRE_ACQUISITION_LENGTH(pre_len),
        .H_GAIN_TDATA(H_GAIN_TDATA),
        .L_GAIN_TDATA(L_GAIN_TDATA),
        .TRIGGER(TRIGGER),
        .SATURATION_FLAG(SATURATION_FLAG),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST(M_AXIS_TLAST),
        .DROPPED_FRAME_COUNT(DROPPED_FRAME_COUNT)
    );

    function automatic logic [128:0] hdr(input logic [47:0] t);
        return {1'b0, 8'hAA, 8'h3C, t, 64'h0};
    endfunction
    function automatic logic [128:0] dat(input logic [47:0] t, input logic l);
        return {1'b0, l ? 8'hB2 : 8'hA1, 104'h0, t[15:0]};
    endfunction
    function automatic logic [128:0] ftr(input logic [15:0] n, input logic g, input logic o);
        return {1'b1, 8'h55, 8'h3C, n, g, o, 94'h0};
    endfunction

    task automatic check(input string name, input logic [128:0] got, input logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask
    task automatic drive(input logic trig, input logic sat);
        TRIGGER = trig;
        SATURATION_FLAG = sat;
        @(posedge ACLK);
        #1;
    endtask
    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge ACLK);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout: %0d beats outstanding, required 0", name, sb.size());
            sb.delete();
        end
        repeat (3) drive(1'b0, 1'b0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge ACLK);
                if (!ARESET && M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat got %h required none", {M_AXIS_TLAST, M_AXIS_TDATA});
                    end else check("beat", {M_AXIS_TLAST, M_AXIS_TDATA}, sb.pop_front());
                end
            end
        join_none
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_tvalid", 129'(M_AXIS_TVALID), 129'd0);
        check("rst_tlast", 129'(M_AXIS_TLAST), 129'd0);
        check("rst_tdata", 129'(M_AXIS_TDATA), 129'd0);
        check("rst_dropped", 129'(DROPPED_FRAME_COUNT), 129'd0);
        ARESET = 1'b0;
        SET_CONFIG = 1'b1;
        drive(1'b0, 1'b0);
        SET_CONFIG = 1'b0;
        repeat (6) drive(1'b0, 1'b0);
        // 1: plain 3-cycle window, PRE=1 so data lags input by 3 cycles
        r = ts_m;
        sb.push_back(hdr(r));
        for (int i = 0; i < 3; i++) sb.push_back(dat(r + 48'(i) - 48'd3, 1'b0));
        sb.push_back(ftr(16'd3, 1'b0, 1'b0));
        repeat (3) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        wait_drain("t1");
        // 2: saturation on the second window cycle selects low gain for beat 2
        r = ts_m;
        sb.push_back(hdr(r));
        sb.push_back(dat(r - 48'd3, 1'b0));
        sb.push_back(dat(r - 48'd2, 1'b1));
        sb.push_back(dat(r - 48'd1, 1'b0));
        sb.push_back(ftr(16'd3, 1'b1, 1'b0));
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        wait_drain("t2");
        // 3: single-cycle gap merges into one 5-beat frame
        r = ts_m;
        sb.push_back(hdr(r));
        for (int i = 0; i < 5; i++) sb.push_back(dat(r + 48'(i) - 48'd3, 1'b0));
        sb.push_back(ftr(16'd5, 1'b0, 1'b0));
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        wait_drain("t3");
        // 4: stalled output, 20-cycle window overflows after 14 data beats
        M_AXIS_TREADY = 1'b0;
        r = ts_m;
        sb.push_back(hdr(r));
        for (int i = 0; i < 14; i++) sb.push_back(dat(r + 48'(i) - 48'd3, 1'b0));
        sb.push_back(ftr(16'd14, 1'b0, 1'b1));
        repeat (20) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        check("stall_tvalid", 129'(M_AXIS_TVALID), 129'd1);
        check("stall_head", {M_AXIS_TLAST, M_AXIS_TDATA}, hdr(r));
        // 5: window while full is dropped whole
        repeat (3) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        check("dropped", 129'(DROPPED_FRAME_COUNT), 129'd1);
        check("stall_hold", {M_AXIS_TLAST, M_AXIS_TDATA}, hdr(r));
        M_AXIS_TREADY = 1'b1;
        wait_drain("t4_drain");
        pre_len = 1'b0;
        repeat (3) drive(1'b0, 1'b0);
        r = ts_m;
        sb.push_back(hdr(r));
        sb.push_back(dat(r - 48'd2, 1'b0));
        sb.push_back(dat(r - 48'd1, 1'b0));
        sb.push_back(ftr(16'd2, 1'b0, 1'b0));
        repeat (2) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        wait_drain("t5_next");
        // 6: asynchronous reset mid-frame
        pre_len = 1'b1;
        repeat (3) drive(1'b0, 1'b0);
        r = ts_m;
        sb.push_back(hdr(r));
        repeat (2) drive(1'b1, 1'b0);
        #1;
        ARESET = 1'b1;
        TRIGGER = 1'b0;
        #1;
        check("async_rst_tvalid", 129'(M_AXIS_TVALID), 129'd0);
        sb.delete();
        repeat (2) @(posedge ACLK);
        #1;
        check("async_rst_dropped", 129'(DROPPED_FRAME_COUNT), 129'd0);
        ARESET = 1'b0;
        repeat (3) drive(1'b0, 1'b0);
        sb.push_back(hdr(48'd3));
        sb.push_back(dat(48'd0, 1'b0));
        sb.push_back(dat(48'd1, 1'b0));
        sb.push_back(ftr(16'd2, 1'b0, 1'b0));
        repeat (2) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        wait_drain("t6");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
